// File: rtl/hex_ascii_streamer.sv
// Streams one captured word as ASCII hex text, one byte per output handshake,
// with optional "0x" prefix, leading-zero suppression and terminator byte.
module hex_ascii_streamer #(
  parameter int         DATA_WIDTH     = 32,
  parameter bit         PREFIX_EN      = 1'b1,
  parameter bit         SUPPRESS_ZEROS = 1'b0,
  parameter bit         TERM_EN        = 1'b1,
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter bit         UPPERCASE      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int NDIG = DATA_WIDTH / 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PFX0   = 3'd1;
  localparam logic [2:0] S_PFX1   = 3'd2;
  localparam logic [2:0] S_DIGITS = 3'd3;
  localparam logic [2:0] S_TERM   = 3'd4;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid && !ready.

  logic [2:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_out_valid;
  logic [7:0]            r_out_char;
  logic                  r_out_last;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_adv;
  logic [2:0]            w_nxt_state;
  logic [IW-1:0]         w_nxt_idx;
  logic [IW-1:0]         w_lead_idx;
  logic [IW-1:0]         w_start_idx;
  logic [DATA_WIDTH-1:0] w_src;
  logic [3:0]            w_nib;
  logic [7:0]            w_nxt_char;
  logic                  w_nxt_last;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) f_hex = 8'h30 + {4'h0, n};
    else           f_hex = (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Highest nonzero nibble wins; an all-zero word leaves the index at 0.
  always_comb begin
    w_lead_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (in_data[4*i +: 4] != 4'h0) w_lead_idx = IW'(i);
    end
  end

  assign w_start_idx = SUPPRESS_ZEROS ? w_lead_idx : IDX_TOP;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          w_nxt_state = PREFIX_EN ? S_PFX0 : S_DIGITS;
          w_nxt_idx   = w_start_idx;
          w_adv       = 1'b1;
        end
      end
      S_PFX0: begin
        if (w_out_fire) begin
          w_nxt_state = S_PFX1;
          w_adv       = 1'b1;
        end
      end
      S_PFX1: begin
        if (w_out_fire) begin
          w_nxt_state = S_DIGITS;
          w_adv       = 1'b1;
        end
      end
      S_DIGITS: begin
        if (w_out_fire) begin
          w_adv = 1'b1;
          if (r_idx == '0) w_nxt_state = TERM_EN ? S_TERM : S_IDLE;
          else             w_nxt_idx   = r_idx - 1'b1;
        end
      end
      S_TERM: begin
        if (w_out_fire) begin
          w_nxt_state = S_IDLE;
          w_adv       = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_adv       = 1'b1;
      end
    endcase
  end

  // The byte for the next state is prepared here and registered, so the
  // outputs come straight from flops and hold still under backpressure.
  assign w_src = (r_state == S_IDLE) ? in_data : r_data;

  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_nxt_idx == IW'(i)) w_nib = w_src[4*i +: 4];
    end
  end

  always_comb begin
    w_nxt_char = 8'h00;
    case (w_nxt_state)
      S_PFX0:   w_nxt_char = 8'h30;
      S_PFX1:   w_nxt_char = 8'h78;
      S_DIGITS: w_nxt_char = f_hex(w_nib);
      S_TERM:   w_nxt_char = TERM_CHAR;
      default:  w_nxt_char = 8'h00;
    endcase
  end

  assign w_nxt_last = (w_nxt_state == S_TERM) ||
                      ((w_nxt_state == S_DIGITS) && (w_nxt_idx == '0) && (TERM_EN == 1'b0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= IDX_TOP;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      if (r_state == S_IDLE) r_data <= in_data;
      r_out_valid <= (w_nxt_state != S_IDLE);
      r_out_char  <= w_nxt_char;
      r_out_last  <= w_nxt_last;
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Bench for hex_ascii_streamer: four parameter variants share clock and reset,
// each with its own expected-byte queue filled by a text model.
module tb_hex_ascii_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        def_in_valid, def_in_ready, def_out_valid, def_out_ready, def_out_last, def_busy;
  logic [31:0] def_in_data;
  logic [7:0]  def_out_char;
  logic [2:0]  def_dbg;
  logic        raw_in_valid, raw_in_ready, raw_out_valid, raw_out_ready, raw_out_last, raw_busy;
  logic [31:0] raw_in_data;
  logic [7:0]  raw_out_char;
  logic [2:0]  raw_dbg;
  logic        sup_in_valid, sup_in_ready, sup_out_valid, sup_out_ready, sup_out_last, sup_busy;
  logic [31:0] sup_in_data;
  logic [7:0]  sup_out_char;
  logic [2:0]  sup_dbg;
  logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_out_last, w8_busy;
  logic [7:0]  w8_in_data;
  logic [7:0]  w8_out_char;
  logic [2:0]  w8_dbg;

  hex_ascii_streamer u_def (
    .clk(clk), .rst(rst), .in_valid(def_in_valid), .in_ready(def_in_ready), .in_data(def_in_data),
    .out_valid(def_out_valid), .out_ready(def_out_ready), .out_char(def_out_char),
    .out_last(def_out_last), .busy(def_busy), .dbg_state(def_dbg));

  hex_ascii_streamer #(.PREFIX_EN(1'b0), .TERM_EN(1'b0), .UPPERCASE(1'b0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(raw_in_valid), .in_ready(raw_in_ready), .in_data(raw_in_data),
    .out_valid(raw_out_valid), .out_ready(raw_out_ready), .out_char(raw_out_char),
    .out_last(raw_out_last), .busy(raw_busy), .dbg_state(raw_dbg));

  hex_ascii_streamer #(.SUPPRESS_ZEROS(1'b1)) u_sup (
    .clk(clk), .rst(rst), .in_valid(sup_in_valid), .in_ready(sup_in_ready), .in_data(sup_in_data),
    .out_valid(sup_out_valid), .out_ready(sup_out_ready), .out_char(sup_out_char),
    .out_last(sup_out_last), .busy(sup_busy), .dbg_state(sup_dbg));

  hex_ascii_streamer #(.DATA_WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_char(w8_out_char),
    .out_last(w8_out_last), .busy(w8_busy), .dbg_state(w8_dbg));

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] q_def[$], q_raw[$], q_sup[$], q_w8[$];
  int hs_cnt[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- per-instance accessors ----------------
  function automatic logic get_ready(input int inst);
    case (inst)
      0: return def_in_ready;
      1: return raw_in_ready;
      2: return sup_in_ready;
      default: return w8_in_ready;
    endcase
  endfunction

  function automatic logic get_valid(input int inst);
    case (inst)
      0: return def_out_valid;
      1: return raw_out_valid;
      2: return sup_out_valid;
      default: return w8_out_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0: return def_busy;
      1: return raw_busy;
      2: return sup_busy;
      default: return w8_busy;
    endcase
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0: return q_def.size();
      1: return q_raw.size();
      2: return q_sup.size();
      default: return q_w8.size();
    endcase
  endfunction

  task automatic push_exp(input int inst, input logic [8:0] e);
    case (inst)
      0: q_def.push_back(e);
      1: q_raw.push_back(e);
      2: q_sup.push_back(e);
      default: q_w8.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int inst, output logic ok, output logic [8:0] e);
    ok = (qsize(inst) != 0);
    e  = '0;
    if (ok) begin
      case (inst)
        0: e = q_def.pop_front();
        1: e = q_raw.pop_front();
        2: e = q_sup.pop_front();
        default: e = q_w8.pop_front();
      endcase
    end
  endtask

  task automatic set_ready(input int inst, input logic r);
    case (inst)
      0: def_out_ready = r;
      1: raw_out_ready = r;
      2: sup_out_ready = r;
      default: w8_out_ready = r;
    endcase
  endtask

  task automatic drive_in(input int inst, input logic v, input logic [31:0] d);
    case (inst)
      0: begin def_in_valid = v; def_in_data = d; end
      1: begin raw_in_valid = v; raw_in_data = d; end
      2: begin sup_in_valid = v; sup_in_data = d; end
      default: begin w8_in_valid = v; w8_in_data = d[7:0]; end
    endcase
  endtask

  // Text model: walk nibbles MSB first, start printing at the first nonzero
  // one (or immediately without suppression), always print the units digit.
  task automatic model(input int inst, input logic [31:0] data);
    int nd; bit p, s, t, u, seen;
    logic [3:0] nib;
    logic [7:0] ch;
    logic [31:0] tmp;
    case (inst)
      0: begin nd = 8; p = 1; s = 0; t = 1; u = 1; end
      1: begin nd = 8; p = 0; s = 0; t = 0; u = 0; end
      2: begin nd = 8; p = 1; s = 1; t = 1; u = 1; end
      default: begin nd = 2; p = 1; s = 0; t = 1; u = 1; end
    endcase
    if (p) begin
      push_exp(inst, {1'b0, 8'h30});
      push_exp(inst, {1'b0, 8'h78});
    end
    seen = !s;
    for (int i = nd - 1; i >= 0; i--) begin
      tmp = data >> (4 * i);
      nib = tmp[3:0];
      if (nib != 4'h0 || i == 0) seen = 1;
      if (seen) begin
        if (nib < 10) ch = "0" + 8'(nib);
        else          ch = (u ? "A" : "a") + 8'(nib) - 8'd10;
        push_exp(inst, {(i == 0) && !t, ch});
      end
    end
    if (t) push_exp(inst, {1'b1, 8'h0A});
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_hs(input int inst, input logic [8:0] got);
    logic ok;
    logic [8:0] e;
    pop_exp(inst, ok, e);
    hs_cnt[inst]++;
    if (!ok) check($sformatf("extra_byte_i%0d", inst), {55'd0, got}, 64'h1ff_dead);
    else     check($sformatf("byte_i%0d_n%0d", inst, hs_cnt[inst]), {55'd0, got}, {55'd0, e});
  endtask

  logic       st_prev = 1'b0;
  logic [8:0] st_val;
  int         w8_lasts = 0;
  int         w8_gap = 0;
  bit         w8_gap_armed = 0;

  always @(negedge clk) begin
    if (rst) begin
      st_prev = 1'b0;
    end else begin
      if (def_out_valid && def_out_ready) mon_hs(0, {def_out_last, def_out_char});
      if (raw_out_valid && raw_out_ready) mon_hs(1, {raw_out_last, raw_out_char});
      if (sup_out_valid && sup_out_ready) mon_hs(2, {sup_out_last, sup_out_char});
      if (w8_out_valid && w8_out_ready)   mon_hs(3, {w8_out_last, w8_out_char});
      if (def_busy) check("def_ready_while_busy", {63'd0, def_in_ready}, 64'd0);
      if (st_prev) begin
        check("stall_valid", {63'd0, def_out_valid}, 64'd1);
        check("stall_hold", {55'd0, def_out_last, def_out_char}, {55'd0, st_val});
      end
      st_prev = def_out_valid && !def_out_ready;
      st_val  = {def_out_last, def_out_char};
      if (w8_out_valid && w8_out_ready && w8_out_last) begin
        w8_lasts++;
        if (w8_lasts == 1) begin w8_gap_armed = 1; w8_gap = 0; end
      end else if (w8_gap_armed) begin
        if (!w8_out_valid) w8_gap++;
        else begin
          check("w8_idle_gap", 64'(w8_gap), 64'd1);
          w8_gap_armed = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int inst, input logic [31:0] data);
    int g = 0;
    @(negedge clk);
    while (!get_ready(inst) && g < 200) begin @(negedge clk); g++; end
    check($sformatf("send_ready_i%0d", inst), {63'd0, get_ready(inst)}, 64'd1);
    drive_in(inst, 1'b1, data);
    model(inst, data);
    @(posedge clk); #1;
    drive_in(inst, 1'b0, data);
    check($sformatf("first_latency_i%0d", inst), {63'd0, get_valid(inst)}, 64'd1);
  endtask

  task automatic drain(input int inst, input bit rnd);
    int g = 0;
    while (qsize(inst) != 0 && g < 400) begin
      @(posedge clk); #1;
      if (rnd) set_ready(inst, 1'($urandom_range(0, 1)));
      g++;
    end
    set_ready(inst, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("drain_i%0d", inst), 64'(qsize(inst)), 64'd0);
    check($sformatf("idle_i%0d", inst), {63'd0, get_busy(inst)}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int base, g;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_in(i, 1'b0, 32'd0);
      set_ready(i, 1'b1);
      hs_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", {63'd0, def_in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, def_out_valid}, 64'd0);
    check("rst_out_char", {56'd0, def_out_char}, 64'd0);
    check("rst_out_last", {63'd0, def_out_last}, 64'd0);
    check("rst_busy", {63'd0, def_busy}, 64'd0);
    check("rst_in_ready_high", {63'd0, def_in_ready}, 64'd1);

    base = hs_cnt[0];
    send(0, 32'hDEADBEEF);
    drain(0, 0);
    check("deadbeef_bytes", 64'(hs_cnt[0] - base), 64'd11);

    send(1, 32'h00C0FFEE);
    drain(1, 0);
    check("raw_bytes", 64'(hs_cnt[1]), 64'd8);

    base = hs_cnt[2];
    send(2, 32'h000000A5);
    drain(2, 0);
    check("sup_a5_bytes", 64'(hs_cnt[2] - base), 64'd5);
    base = hs_cnt[2];
    send(2, 32'h0);
    drain(2, 0);
    check("sup_zero_bytes", 64'(hs_cnt[2] - base), 64'd4);

    base = hs_cnt[0];
    send(0, 32'h12345678);
    drain(0, 1);
    check("bp_handshakes", 64'(hs_cnt[0] - base), 64'd11);

    // Reset after the 4th byte of a word; the remaining bytes must never appear.
    base = hs_cnt[0];
    send(0, 32'hCAFEBABE);
    g = 0;
    while (hs_cnt[0] < base + 4 && g < 100) begin @(posedge clk); g++; end
    check("mid_reset_reached", 64'(hs_cnt[0] - base), 64'd4);
    #1;
    rst = 1'b1;
    def_out_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", {63'd0, def_in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q_def.delete();
    @(negedge clk);
    check("post_rst_valid", {63'd0, def_out_valid}, 64'd0);
    check("post_rst_busy", {63'd0, def_busy}, 64'd0);
    check("post_rst_in_ready", {63'd0, def_in_ready}, 64'd1);
    check("post_rst_char", {56'd0, def_out_char}, 64'd0);
    def_out_ready = 1'b1;
    base = hs_cnt[0];
    send(0, 32'h00000001);
    drain(0, 0);
    check("post_rst_word_bytes", 64'(hs_cnt[0] - base), 64'd11);

    // Back-to-back 8-bit words with in_valid held high throughout.
    @(negedge clk);
    w8_in_valid = 1'b1;
    w8_in_data  = 8'h3F;
    model(3, 32'h3F);
    @(posedge clk); #1;
    w8_in_data = 8'hF0;
    model(3, 32'hF0);
    g = 0;
    @(negedge clk);
    while (!w8_in_ready && g < 50) begin @(negedge clk); g++; end
    check("w8_second_ready", {63'd0, w8_in_ready}, 64'd1);
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    drain(3, 0);
    check("w8_bytes", 64'(hs_cnt[3]), 64'd10);
    check("w8_lasts", 64'(w8_lasts), 64'd2);

    for (int k = 0; k < 4; k++) begin
      send(0, $urandom);
      drain(0, 1);
      send(2, $urandom >> $urandom_range(0, 31));
      drain(2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_ascii_streamer.md
Name: hex_ascii_streamer

Overview:
Parametrised, sequential hex-to-ASCII formatter. It accepts one DATA_WIDTH-bit word per input handshake and emits its hexadecimal text one ASCII byte per output handshake, with optional "0x" prefix, leading-zero suppression and terminator character. It sits between debug/register-dump sources (register file, PC, ALU result taps) and the byte-wide UART/LCD text sinks of the processor debug path.

Parameters:
DATA_WIDTH, 32, input word width; must be a multiple of 4 and in the range 4..64; NDIG = DATA_WIDTH/4
PREFIX_EN, 1, 1 = emit "0x" (8'h30, 8'h78) before the digits
SUPPRESS_ZEROS, 0, 1 = drop leading zero digits; an all-zero word still emits a single '0'
TERM_EN, 1, 1 = emit TERM_CHAR after the last digit
TERM_CHAR, 8'h0A, terminator byte
UPPERCASE, 1, 1 = A-F as 8'h41-8'h46; 0 = a-f as 8'h61-8'h66

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  DATA_WIDTH  word to format
out_valid  output  1  out_char is valid
out_ready  input  1  sink accepts out_char
out_char  output  8  current ASCII byte
out_last  output  1  high with the final byte of the current word
busy  output  1  high in any state other than IDLE

Interface: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, out_valid=0, out_char=8'h00, out_last=0, busy=0, digit index=NDIG-1, data register cleared. rst takes priority over every other event, including reset in the middle of a stream: the partial word is abandoned and no further bytes are emitted. While rst is high, in_ready=0.
- in_ready = (state==IDLE) && !rst. This is combinational from registered state.
- Capture: when in_valid && in_ready at a rising edge, register in_data and compute the start digit index.
  - SUPPRESS_ZEROS=0: start index = NDIG-1.
  - SUPPRESS_ZEROS=1: start index = index of the most significant nonzero nibble, or 0 if the word is zero.
  - Next state: PFX0 if PREFIX_EN, else DIGITS.
- Latency: the first byte has out_valid=1 in the cycle after capture.
- States:
  - IDLE
  - PFX0 emits '0', then goes to PFX1.
  - PFX1 emits 'x', then goes to DIGITS.
  - DIGITS emits the nibble at the current index, decrementing the index on each accepted byte; after index 0 it goes to TERM if TERM_EN, else IDLE.
  - TERM emits TERM_CHAR, then goes to IDLE.
  - Transitions occur only on an output handshake (out_valid && out_ready).
- Nibble mapping: 0-9 map to 8'h30+n. 10-15 map to 8'h41+(n-10) when UPPERCASE, else 8'h61+(n-10).
- out_char and out_last are registered. They must stay stable while out_valid && !out_ready; no byte is skipped or duplicated under backpressure.
- out_last=1 only on the final byte: TERM_CHAR if TERM_EN, else digit index 0.
- After the last handshake the block enters IDLE with out_valid=0 in the next cycle. The minimum gap between words is 1 cycle (a new word is accepted in the IDLE cycle). in_data changes while busy are ignored.
- Bytes per word = 2*PREFIX_EN + digits emitted + TERM_EN.
- out_valid may stay high across consecutive bytes of the same word when out_ready is held high, giving 1 byte per cycle.

Test Plan:
1. Defaults, in_data=32'hDEADBEEF, out_ready=1 -> 11 consecutive bytes "0xDEADBEEF\n" (30 78 44 45 41 44 42 45 45 46 0A). First byte appears 1 cycle after capture; out_last only on 8'h0A; in_ready=0 throughout.
2. UPPERCASE=0, PREFIX_EN=0, TERM_EN=0, in_data=32'h00C0FFEE -> "00c0ffee", 8 bytes, out_last on the final 'e'.
3. SUPPRESS_ZEROS=1: in_data=32'h000000A5 -> "0xA5\n"; in_data=32'h0 -> "0x0\n" (out_last on 8'h0A).
4. Backpressure, defaults, in_data=32'h12345678, out_ready pseudo-random about 50% -> exact byte sequence "0x12345678\n"; out_char constant during every stall; total handshakes = 11.
5. Reset mid-stream: assert rst for 1 cycle after the 4th byte of 32'hCAFEBABE -> next cycle out_valid=0, busy=0; in_ready=1 the cycle after rst falls; a following word 32'h1 streams "0x00000001\n" cleanly.
6. DATA_WIDTH=8, back-to-back words 8'h3F then 8'hF0 with in_valid held high -> "0x3F\n" then "0xF0\n", with exactly one idle cycle (out_valid=0) between the two streams.
